// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// data first, with a starvation limit that forces a fetch grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  state_t state;
  owner_t pick;
  logic   dm_req;
  logic   arb_ok;
  logic   grant;
  logic   starve_sat;
  logic   cnt_inc;
  logic   cnt_clr;

  assign dm_req   = dm_rd | dm_wr;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // A done pulse means the owner's request is still visibly held for this
  // cycle, so nothing is granted until the requesters have had a cycle to update.
  assign arb_ok = (state == IDLE) & ~if_done & ~dm_done;

  always_comb begin
    pick    = OWN_IF;
    grant   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (arb_ok) begin
      if (dm_req && (!if_req || !starve_sat)) begin
        pick    = OWN_DM;
        grant   = 1'b1;
        cnt_inc = if_req;
        cnt_clr = ~if_req;
      end else if (if_req) begin
        pick    = OWN_IF;
        grant   = 1'b1;
        cnt_clr = 1'b1;
      end
    end
  end

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_data   <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            mem_en <= 1'b1;
            if (pick == OWN_DM) begin
              state     <= DM_BUSY;
              mem_wr    <= dm_wr;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (dm_rd && dm_wr) begin
                err <= 1'b1;
              end
            end else begin
              state    <= IF_BUSY;
              mem_wr   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        IF_BUSY: begin
          if (mem_done) begin
            if_done <= 1'b1;
            if_data <= mem_rdata;
            state   <= IDLE;
          end
        end
        DM_BUSY: begin
          if (mem_done) begin
            dm_done <= 1'b1;
            if (!mem_wr) begin
              dm_rdata <= mem_rdata;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
